// File: rtl/forward_ctrl_unit_pkg.sv
// Shared definitions for the EX operand forwarding / load-use control.
//   - FWD_* : select codes driven to the EX 3-to-1 operand muxes
//   - REG_ADDR_W_DEF : default register index width
//   - shadow_stage_t : per-stage shadow record {valid, rd, reg_write, mem_read}
package forward_ctrl_unit_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
  } shadow_stage_t;

  function automatic shadow_stage_t shadow_empty();
    return '0;
  endfunction

endpackage

// File: rtl/forward_ctrl_unit_sel_compare.sv
// fwd_sel_compare: combinational per-operand producer priority compare.
//   rs, use_rs                       : source register and whether it is read
//   ex_valid/ex_reg_write/ex_rd      : youngest in-flight producer (EX)
//   mem_valid/mem_reg_write/mem_rd   : next older producer (MEM)
//   sel                              : FWD_EXMEM, FWD_MEMWB or FWD_REGFILE
module fwd_sel_compare
  import forward_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  use_rs,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic [1:0]            sel
);

  logic ex_hit;
  logic mem_hit;

  // x0 is hardwired zero, so a producer writing it never matches.
  assign ex_hit  = ex_valid  & ex_reg_write  & (ex_rd  != '0) & (ex_rd  == rs);
  assign mem_hit = mem_valid & mem_reg_write & (mem_rd != '0) & (mem_rd == rs);

  // EX is checked first: the youngest producer holds the newest value.
  always_comb begin
    sel = FWD_REGFILE;
    if (use_rs && ex_hit) begin
      sel = FWD_EXMEM;
    end else if (use_rs && mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forward_ctrl_unit.sv
// forward_ctrl_unit: forwarding select generation and load-use stall for
// the EX stage of the 5-stage riscv32 pipeline.
//   clk, rst              : clock, asynchronous active-high reset
//   id_*                  : instruction currently in ID (moving to EX)
//   ex_flush              : squash the instruction entering EX
//   fwd_a_sel/fwd_b_sel   : registered operand selects, valid while in EX
//   stall                 : combinational load-use stall (one cycle per pair)
//   stall_cycles          : saturating count of stall cycles
// The shadow stage record width is REG_ADDR_W_DEF; REG_ADDR_W must match it.
module forward_ctrl_unit
  import forward_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cycles
);

  shadow_stage_t ex_reg;
  shadow_stage_t mem_reg;
  shadow_stage_t wb_reg;
  shadow_stage_t ex_next;

  logic [1:0] sel_a_next;
  logic [1:0] sel_b_next;
  logic       kill_ex;
  logic       unused_shadow;

  // A load still in EX has no data yet; the dependent instruction must wait
  // one cycle, after which the load sits in MEM and is forwarded from MEM/WB.
  assign stall = id_valid & ex_reg.valid & ex_reg.mem_read & (ex_reg.rd != '0) &
                 ((id_use_rs1 & (ex_reg.rd == id_rs1)) |
                  (id_use_rs2 & (ex_reg.rd == id_rs2)));

  assign kill_ex = stall | ex_flush | ~id_valid;

  always_comb begin
    ex_next           = shadow_empty();
    ex_next.valid     = ~kill_ex;
    ex_next.rd        = id_rd;
    ex_next.reg_write = id_reg_write;
    ex_next.mem_read  = id_mem_read;
  end

  fwd_sel_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs1 (
    .rs            (id_rs1),
    .use_rs        (id_use_rs1),
    .ex_valid      (ex_reg.valid),
    .ex_reg_write  (ex_reg.reg_write),
    .ex_rd         (ex_reg.rd),
    .mem_valid     (mem_reg.valid),
    .mem_reg_write (mem_reg.reg_write),
    .mem_rd        (mem_reg.rd),
    .sel           (sel_a_next)
  );

  fwd_sel_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs2 (
    .rs            (id_rs2),
    .use_rs        (id_use_rs2),
    .ex_valid      (ex_reg.valid),
    .ex_reg_write  (ex_reg.reg_write),
    .ex_rd         (ex_reg.rd),
    .mem_valid     (mem_reg.valid),
    .mem_reg_write (mem_reg.reg_write),
    .mem_rd        (mem_reg.rd),
    .sel           (sel_b_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg       <= shadow_empty();
      mem_reg      <= shadow_empty();
      wb_reg       <= shadow_empty();
      fwd_a_sel    <= FWD_REGFILE;
      fwd_b_sel    <= FWD_REGFILE;
      stall_cycles <= '0;
    end else begin
      ex_reg    <= ex_next;
      mem_reg   <= ex_reg;
      wb_reg    <= mem_reg;
      // A bubble or squashed slot in EX must never steer the operand muxes.
      fwd_a_sel <= kill_ex ? FWD_REGFILE : sel_a_next;
      fwd_b_sel <= kill_ex ? FWD_REGFILE : sel_b_next;
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  // The WB shadow stage and MEM's load flag take part in no decision: a WB
  // producer is covered by the write-first register file, and loads only
  // matter while in EX. They are kept so the shadow mirrors the real pipeline.
  assign unused_shadow = ^{wb_reg, mem_reg.mem_read};

endmodule
